// File: rtl/pattern_gen.sv
// pattern_gen: Wishbone-loaded 64-bit pattern buffer played out one word per clock
module pattern_gen #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trig_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d, len_q, len_d, addr_q, addr_d;
    logic                  loop_q, loop_d, wait_trig_q, wait_trig_d;
    logic [31:0]           lo_stage_q, lo_stage_d;
    logic [63:0]           idle_val_q, idle_val_d;
    logic                  trig_q;
    logic [63:0]           mem [DEPTH];
    logic [63:0]           rd_q;
    logic                  rd_vld_q, rd_vld_d;
    logic [63:0]           data_q;
    logic                  valid_q;
    logic [7:0]            adr;
    logic                  wr, cfg_wr, abort, mem_we, unused_adr;

    assign adr        = wbs_adr_i[7:0];
    assign unused_adr = ^wbs_adr_i[31:8];
    assign wr         = wbs_stb_i & wbs_we_i;
    assign cfg_wr     = wr & (state_q == IDLE);
    assign abort      = wr & (adr == 8'h20);
    assign mem_we     = cfg_wr & (adr == 8'h10);
    assign wbs_ack_o  = wbs_stb_i;
    assign data_o     = data_q;
    assign valid_o    = valid_q;

    // sequencer, register writes and read-pipeline enable
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        addr_d      = addr_q;
        loop_d      = loop_q;
        wait_trig_d = wait_trig_q;
        lo_stage_d  = lo_stage_q;
        idle_val_d  = idle_val_q;
        case (state_q)
            IDLE: if (cfg_wr && adr == 8'h00 && wbs_dat_i[0]) begin
                state_d = wbs_dat_i[1] ? ARMED : PLAY;
                idx_d   = '0;
            end
            ARMED: if (trig_q) begin
                state_d = PLAY;
                idx_d   = '0;
            end
            PLAY: begin
                idx_d = (idx_q == len_q) ? '0 : idx_q + 1'b1;
                if (idx_q == len_q && !loop_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
        if (cfg_wr) begin
            case (adr)
                8'h00: begin
                    wait_trig_d = wbs_dat_i[1];
                    loop_d      = wbs_dat_i[2];
                end
                8'h04: len_d = wbs_dat_i[DEPTH_LOG2-1:0];
                8'h08: addr_d = wbs_dat_i[DEPTH_LOG2-1:0];
                8'h0C: lo_stage_d = wbs_dat_i;
                8'h10: addr_d = addr_q + 1'b1;
                8'h14: idle_val_d[31:0] = wbs_dat_i;
                8'h18: idle_val_d[63:32] = wbs_dat_i;
                default: ;
            endcase
        end
        rd_vld_d = (state_q == PLAY) && !abort;
    end

    // control state, output register and trigger synchroniser
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            loop_q      <= 1'b0;
            wait_trig_q <= 1'b0;
            lo_stage_q  <= '0;
            idle_val_q  <= '0;
            trig_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            loop_q      <= loop_d;
            wait_trig_q <= wait_trig_d;
            lo_stage_q  <= lo_stage_d;
            idle_val_q  <= idle_val_d;
            trig_q      <= trig_i;
            rd_vld_q    <= rd_vld_d;
            data_q      <= rd_vld_q ? rd_q : idle_val_q;
            valid_q     <= rd_vld_q;
        end
    end

    // pattern buffer: synchronous write port from the bus, synchronous read at the play index
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[addr_q] <= {wbs_dat_i, lo_stage_q};
        rd_q <= mem[idx_q];
    end

    // combinational register readback
    always_comb begin
        case (adr)
            8'h00:   wbs_dat_o = {29'b0, loop_q, wait_trig_q, state_q == IDLE};
            8'h04:   wbs_dat_o = 32'(len_q);
            8'h08:   wbs_dat_o = 32'(addr_q);
            8'h0C:   wbs_dat_o = lo_stage_q;
            8'h10:   wbs_dat_o = 32'h0;
            8'h14:   wbs_dat_o = idle_val_q[31:0];
            8'h18:   wbs_dat_o = idle_val_q[63:32];
            8'h20:   wbs_dat_o = 32'h0;
            8'h24:   wbs_dat_o = 32'(idx_q);
            default: wbs_dat_o = 32'h50415447;
        endcase
    end
endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: scoreboard bench for the pattern generator
module tb_pattern_gen;
    logic        clk = 1'b0;
    logic        rst_i, trig_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic [31:0] wbs_dat_i, wbs_dat_o, wbs_adr_i;
    logic        wbs_ack_o, wbs_stb_i, wbs_we_i;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] IDLE_V = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] X_W    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] Y_W    = 64'h5555_6666_7777_8888;

    pattern_gen #(.DEPTH_LOG2(9)) dut (
        .clk_i(clk), .rst_i(rst_i), .trig_i(trig_i), .data_o(data_o), .valid_o(valid_o),
        .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .wbs_adr_i(wbs_adr_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] w(input int k);
        return {32'(32'hA0 + k), 32'(32'hB0 + k)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
        wbs_adr_i = {24'b0, a};
        wbs_dat_i = d;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        @(posedge clk);
        #1;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        wbs_adr_i = {24'b0, a};
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        #1;
        check(tag, {32'b0, wbs_dat_o}, {32'b0, exp});
        check({tag, "_ack"}, {63'b0, wbs_ack_o}, 64'd1);
        wbs_stb_i = 1'b0;
    endtask

    // every valid output word must match the next scoreboard entry
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_valid", {63'b0, valid_o}, 64'd0);
            else begin
                mon_exp = exp_q.pop_front();
                check("word", data_o, mon_exp);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; trig_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'b0, valid_o}, 64'd0);
        check("rst_data", data_o, 64'd0);
        rst_i = 1'b0;
        rd_check("rst_ctrl", 8'h00, 32'h1);
        rd_check("rst_len", 8'h04, 32'h0);
        rd_check("rst_addr", 8'h08, 32'h0);
        // load four words and play them once
        wb_wr(8'h08, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wb_wr(8'h0C, 32'hB0 + k);
            wb_wr(8'h10, 32'hA0 + k);
        end
        wb_wr(8'h04, 32'd3);
        for (int k = 0; k < 4; k++) exp_q.push_back(w(k));
        wb_wr(8'h00, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            step;
            check("oneshot_valid", {63'b0, valid_o}, 64'(i >= 2 && i <= 5));
        end
        check("oneshot_idle", data_o, 64'd0);
        check("oneshot_drained", 64'(exp_q.size()), 64'd0);
        rd_check("oneshot_ctrl", 8'h00, 32'h1);
        // idle value and triggered start
        wb_wr(8'h14, IDLE_V[31:0]);
        wb_wr(8'h18, IDLE_V[63:32]);
        step;
        check("idle_visible", data_o, IDLE_V);
        wb_wr(8'h00, 32'h3);
        for (int i = 0; i < 10; i++) begin
            step;
            check("armed_valid", {63'b0, valid_o}, 64'd0);
            check("armed_data", data_o, IDLE_V);
        end
        rd_check("armed_ctrl", 8'h00, 32'h2);
        for (int k = 0; k < 4; k++) exp_q.push_back(w(k));
        trig_i = 1'b1;
        step;
        trig_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step;
            check("trig_valid", {63'b0, valid_o}, 64'(i >= 3 && i <= 6));
        end
        check("trig_idle", data_o, IDLE_V);
        check("trig_drained", 64'(exp_q.size()), 64'd0);
        rd_check("trig_ctrl", 8'h00, 32'h3);
        // looping playback of three words, then abort
        wb_wr(8'h04, 32'd2);
        for (int i = 0; i < 21; i++) exp_q.push_back(w(i % 3));
        wb_wr(8'h00, 32'h5);
        repeat (21) step;
        wb_wr(8'h20, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step;
            check("abort_valid", {63'b0, valid_o}, 64'd0);
            check("abort_data", data_o, IDLE_V);
        end
        check("loop_drained", 64'(exp_q.size()), 64'd0);
        rd_check("abort_ctrl", 8'h00, 32'h5);
        // configuration writes during playback must be ignored
        wb_wr(8'h04, 32'd3);
        for (int i = 0; i < 12; i++) exp_q.push_back(w(i % 4));
        wb_wr(8'h00, 32'h5);
        wb_wr(8'h04, 32'd7);
        wb_wr(8'h08, 32'h10);
        wb_wr(8'h10, 32'hFFFF_FFFF);
        repeat (9) step;
        wb_wr(8'h20, 32'h0);
        step;
        check("ign_valid", {63'b0, valid_o}, 64'd0);
        check("ign_drained", 64'(exp_q.size()), 64'd0);
        rd_check("ign_len", 8'h04, 32'd3);
        rd_check("ign_addr", 8'h08, 32'd4);
        for (int k = 0; k < 4; k++) exp_q.push_back(w(k));
        wb_wr(8'h00, 32'h1);
        repeat (7) step;
        check("replay_drained", 64'(exp_q.size()), 64'd0);
        // write pointer wrap and single-word playback
        wb_wr(8'h08, 32'd511);
        wb_wr(8'h0C, X_W[31:0]);
        wb_wr(8'h10, X_W[63:32]);
        wb_wr(8'h0C, Y_W[31:0]);
        wb_wr(8'h10, Y_W[63:32]);
        rd_check("wrap_addr", 8'h08, 32'd1);
        wb_wr(8'h04, 32'd0);
        exp_q.push_back(Y_W);
        wb_wr(8'h00, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step;
            check("len0_valid", {63'b0, valid_o}, 64'(i == 2));
        end
        check("len0_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 5; i++) exp_q.push_back(Y_W);
        wb_wr(8'h00, 32'h5);
        repeat (5) step;
        wb_wr(8'h20, 32'h0);
        step;
        check("len0loop_valid", {63'b0, valid_o}, 64'd0);
        check("len0loop_drained", 64'(exp_q.size()), 64'd0);
        // reset in the middle of playback
        wb_wr(8'h04, 32'd3);
        exp_q.push_back(Y_W);
        wb_wr(8'h00, 32'h5);
        step;
        step;
        rst_i = 1'b1;
        step;
        check("midrst_valid", {63'b0, valid_o}, 64'd0);
        check("midrst_data", data_o, 64'd0);
        rst_i = 1'b0;
        check("midrst_drained", 64'(exp_q.size()), 64'd0);
        rd_check("midrst_ctrl", 8'h00, 32'h1);
        rd_check("midrst_len", 8'h04, 32'h0);
        rd_check("midrst_addr", 8'h08, 32'h0);
        rd_check("unmapped", 8'h80, 32'h50415447);
        step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
